// File: rtl/moore_run_detector.sv
// Moore run detector: z asserts once RUN_LEN consecutive sampled 1s have been seen on w.
// Optional hit counter is enabled by defining MOORE_RUN_HIT_CNT_EN.
`timescale 1ns/1ps
module moore_run_detector #(
   parameter int unsigned RUN_LEN = 2,
   parameter int unsigned CNT_W   = 3,
   parameter int unsigned HIT_W   = 8
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             w,
   input  logic             en,
   input  logic             clear,
   input  logic             ovl,
   output logic             z,
   output logic [CNT_W-1:0] run_cnt
`ifdef MOORE_RUN_HIT_CNT_EN
   ,
   output logic [HIT_W-1:0] hit_cnt
`endif
);

   if (RUN_LEN < 1 || RUN_LEN > (2 ** CNT_W) - 1 || HIT_W < 1) begin : g_bad_param
      $error("moore_run_detector: illegal RUN_LEN/CNT_W/HIT_W combination");
   end

   typedef enum logic [1:0] {StIdle, StCount, StDetect} state_e;

   localparam logic [CNT_W-1:0] RunLen = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CntOne;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (en) begin
         unique case (state_q)
            StIdle: begin
               if (w) begin
                  state_d = (RUN_LEN == 1) ? StDetect : StCount;
                  cnt_d   = CntOne;
               end else begin
                  cnt_d = '0;
               end
            end
            StCount: begin
               if (w) begin
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == RunLen) ? StDetect : StCount;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end
            StDetect: begin
               if (!w) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (ovl) begin
                  state_d = StDetect;
                  cnt_d   = RunLen;
               end else begin
                  // Non-overlapping: this 1 starts a fresh run.
                  state_d = (RUN_LEN == 1) ? StDetect : StCount;
                  cnt_d   = CntOne;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign z       = (state_q == StDetect);
   assign run_cnt = cnt_q;

`ifdef MOORE_RUN_HIT_CNT_EN
   localparam logic [HIT_W-1:0] HitMax = '1;

   logic [HIT_W-1:0] hit_q, hit_d;
   logic             hit_inc;

   // One increment per distinct hit; staying in DETECT with ovl=1 is the same hit.
   assign hit_inc = en && !clear && (state_d == StDetect) && ((state_q != StDetect) || !ovl);

   always_comb begin
      hit_d = hit_q;
      if (clear) begin
         hit_d = '0;
      end else if (hit_inc && (hit_q != HitMax)) begin
         hit_d = hit_q + HIT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         hit_q <= '0;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_moore_run_detector.sv
// Self-checking bench for moore_run_detector: three instances (RUN_LEN 2, 4, 1) driven
// from a shared stimulus table, with expected results passed through a scoreboard queue.
`timescale 1ns/1ps
module tb_moore_run_detector;

   logic Clock = 1'b0;
   logic Resetn = 1'b0;
   logic w = 1'b0, en = 1'b0, clear = 1'b0, ovl = 1'b0;

   logic       z0, z1, z2;
   logic [2:0] c0, c1, c2;
   logic [7:0] h0, h1;
   logic [1:0] h2;

   always #5 Clock = ~Clock;

`ifdef MOORE_RUN_HIT_CNT_EN
   moore_run_detector #(.RUN_LEN(2), .CNT_W(3), .HIT_W(8)) u_rl2 (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .clear(clear), .ovl(ovl),
      .z(z0), .run_cnt(c0), .hit_cnt(h0));
   moore_run_detector #(.RUN_LEN(4), .CNT_W(3), .HIT_W(8)) u_rl4 (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .clear(clear), .ovl(ovl),
      .z(z1), .run_cnt(c1), .hit_cnt(h1));
   moore_run_detector #(.RUN_LEN(1), .CNT_W(3), .HIT_W(2)) u_rl1 (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .clear(clear), .ovl(ovl),
      .z(z2), .run_cnt(c2), .hit_cnt(h2));
`else
   moore_run_detector #(.RUN_LEN(2), .CNT_W(3)) u_rl2 (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .clear(clear), .ovl(ovl),
      .z(z0), .run_cnt(c0));
   moore_run_detector #(.RUN_LEN(4), .CNT_W(3)) u_rl4 (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .clear(clear), .ovl(ovl),
      .z(z1), .run_cnt(c1));
   moore_run_detector #(.RUN_LEN(1), .CNT_W(3)) u_rl1 (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .clear(clear), .ovl(ovl),
      .z(z2), .run_cnt(c2));
   assign h0 = '0;
   assign h1 = '0;
   assign h2 = '0;
`endif

   typedef struct {
      logic       rst;
      int         dut;
      logic       w, en, clr, ovl;
      logic       z;
      logic [2:0] cnt;
      logic [7:0] hit;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   step_no = 0;

   function automatic vec_t mk(input logic rst, input int dut, input logic vw, input logic ven,
                               input logic vclr, input logic vovl, input logic ez,
                               input int ecnt, input int ehit);
      vec_t v;
      v.rst = rst; v.dut = dut; v.w = vw; v.en = ven; v.clr = vclr; v.ovl = vovl;
      v.z = ez; v.cnt = 3'(ecnt); v.hit = 8'(ehit);
      return v;
   endfunction

   task automatic cmp(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0d, expected %0d", name, step_no, act, exp_v);
      end
   endtask

   task automatic check_dut(input int dut, input logic ez, input int ecnt, input int ehit);
      logic       az;
      logic [2:0] ac;
      logic [7:0] ah;
      case (dut)
         0:       begin az = z0; ac = c0; ah = h0; end
         1:       begin az = z1; ac = c1; ah = h1; end
         default: begin az = z2; ac = c2; ah = {6'b0, h2}; end
      endcase
      cmp($sformatf("dut%0d z", dut), int'(az), int'(ez));
      cmp($sformatf("dut%0d run_cnt", dut), int'(ac), ecnt);
`ifdef MOORE_RUN_HIT_CNT_EN
      cmp($sformatf("dut%0d hit_cnt", dut), int'(ah), ehit);
`else
      if (ah != ah) n_fail++;
`endif
   endtask

   // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
   task automatic do_reset();
      Resetn = 1'b0;
      w = 1'b0; en = 1'b1; clear = 1'b0;
      #2;
      for (int d = 0; d < 3; d++) check_dut(d, 1'b0, 0, 0);
      Resetn = 1'b1;
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      if (v.rst) do_reset();
      w = v.w; en = v.en; clear = v.clr; ovl = v.ovl;
      exp_q.push_back(v);
      @(posedge Clock);
      #1;
      step_no++;
      e = exp_q.pop_front();
      check_dut(e.dut, e.z, int'(e.cnt), int'(e.hit));
   endtask

   initial begin
      // RUN_LEN=2, overlapping: w = 0,0,1,1,1,1,0
      vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 2, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 2, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 2, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 1));
      // RUN_LEN=2, non-overlapping: same stimulus
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 2, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 2, 2));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 2));
      // RUN_LEN=4, overlapping: 1,1,1,0,1,1,1,1,1
      vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 2, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 3, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 2, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 3, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 4, 1));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 4, 1));
      // RUN_LEN=2: freeze in DETECT with en=0, then clear overriding en=0
      vecs.push_back(mk(1, 0, 1, 1, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 2, 1));
      // RUN_LEN=1, HIT_W=2, non-overlapping: hit_cnt saturates at 3
      vecs.push_back(mk(1, 2, 1, 1, 0, 0, 1, 1, 1));
      vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 1, 2));
      vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 1, 3));
      vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 1, 3));
      vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 1, 3));
      vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 1, 3));
      vecs.push_back(mk(0, 2, 0, 1, 0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 2, 1, 1, 0, 1, 1, 1, 3));

      foreach (vecs[i]) step(vecs[i]);

      // Reset dropped mid-cycle while z=1, then a fresh run is needed.
      step(mk(1, 0, 1, 1, 0, 1, 0, 1, 0));
      step(mk(0, 0, 1, 1, 0, 1, 1, 2, 1));
      #2;
      Resetn = 1'b0;
      #1;
      check_dut(0, 1'b0, 0, 0);
      #1;
      Resetn = 1'b1;
      step(mk(0, 0, 1, 1, 0, 1, 0, 1, 0));
      step(mk(0, 0, 1, 1, 0, 1, 1, 2, 1));

      cmp("scoreboard drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/moore_run_detector.md
Name: moore_run_detector

Overview:
- Parameterised Moore-type run detector; successor of the fixed two-ones Moore FSM.
- Asserts z after RUN_LEN consecutive sampled 1s on serial input w.
- Adds overlapping/non-overlapping mode, a sample enable, synchronous clear and a run-length count output.
- Sits on serial control/bit-stream inputs as a reusable pattern/qualifier block.

Parameters:
- RUN_LEN, 2: number of consecutive 1s required for a hit; legal range 1..2^CNT_W-1.
- CNT_W, 3: width of the run counter and run_cnt output.
- HIT_W, 8: width of hit_cnt; used only with the optional feature.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
- w  input  1  serial data, sampled on rising Clock edges when en=1.
- en  input  1  sample enable; 0 freezes state and counter.
- clear  input  1  synchronous clear to IDLE; overrides en.
- ovl  input  1  1 = overlapping detection, 0 = non-overlapping (restart after each hit).
- z  output  1  Moore output; 1 exactly when state = DETECT.
- run_cnt  output  CNT_W  current consecutive-ones count; holds RUN_LEN in DETECT.
- hit_cnt  output  HIT_W  number of hits; present only with MOORE_RUN_HIT_CNT_EN.

Behaviour:
- States: IDLE, COUNT, DETECT; state encoding is free.
- z is decoded from state only, never directly from w; it lags the qualifying sample by one edge.
- Reset (Resetn=0, asynchronous): state=IDLE, run_cnt=0, z=0, hit_cnt=0. Release takes effect at the next rising edge.
- Priority per edge: clear > en=0 (hold everything) > transitions below.
- clear=1: state=IDLE, run_cnt=0, hit_cnt=0, regardless of en and w.
- IDLE:
  - w=0 -> stay in IDLE, run_cnt=0.
  - w=1 -> RUN_LEN=1 ? DETECT (run_cnt=1) : COUNT (run_cnt=1).
- COUNT:
  - w=0 -> IDLE, run_cnt=0.
  - w=1 -> run_cnt+1; if run_cnt+1 = RUN_LEN go to DETECT, else stay in COUNT.
- DETECT:
  - w=0 -> IDLE, run_cnt=0.
  - w=1, ovl=1 -> stay in DETECT, run_cnt holds RUN_LEN (no wrap).
  - w=1, ovl=0 -> RUN_LEN=1 ? DETECT : COUNT, with run_cnt=1 (run restarts; next hit after another RUN_LEN-1 ones).
- ovl may change at any cycle; it is only consulted on the DETECT w=1 transition.
- run_cnt never exceeds RUN_LEN; no arithmetic overflow for legal parameters.
- Reset asserted mid-run: immediate return to IDLE, z=0 without waiting for a clock.
- With RUN_LEN=2 and ovl=1 the block is cycle-equivalent to the original two-consecutive-ones Moore FSM.

Optional Feature:
- Macro MOORE_RUN_HIT_CNT_EN.
- Defined:
  - hit_cnt port and register exist.
  - hit_cnt increments on each edge where next state = DETECT and (current state != DETECT or ovl=0), i.e. once per distinct hit.
  - hit_cnt saturates at 2^HIT_W-1.
  - Cleared by reset and by clear; held when en=0.
- Undefined: hit_cnt port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then w=0 for 2 edges, w=1 for 4 edges, w=0 (RUN_LEN=2, ovl=1, en=1) -> z=0 after the 1st one, z=1 after the 2nd, 3rd and 4th ones, z=0 after the first 0; run_cnt sequence 0,0,1,2,2,2,0; hit_cnt=1.
- Same stimulus with ovl=0 -> z pulses after the 2nd and 4th ones only; run_cnt 1,2,1,2; hit_cnt=2.
- RUN_LEN=4, CNT_W=3, ovl=1: pattern 1,1,1,0,1,1,1,1 -> z stays 0 through the broken run, z=1 after the 8th sample; run_cnt reaches 4 and holds.
- In DETECT, drive en=0 for 3 edges while w toggles -> state, z=1, run_cnt and hit_cnt frozen; clear=1 with en=0 -> z=0, run_cnt=0, hit_cnt=0 at the next edge.
- While z=1, drop Resetn to 0 mid-cycle -> z=0 and run_cnt=0 immediately, before the next edge; after release, a fresh run of RUN_LEN ones is required for z=1.
- Feature on, HIT_W=2, RUN_LEN=1, ovl=0, w=1 for 6 edges -> hit_cnt counts 1,2,3,3,3,3 (saturates); z=1 throughout.
